// File: rtl/sd_cic_decim.sv
// Sinc^ORDER CIC decimator: 1-bit sigma-delta stream in, saturated signed Q1.(DW-1) PCM out
// at one sample per 2^LOG2R accepted bits.
module sd_cic_decim #(
  parameter int DW    = 24,
  parameter int ORDER = 3,
  parameter int LOG2R = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sd_in,
  output logic signed [DW-1:0] out,
  output logic                 out_valid
);

  localparam int W  = ORDER*LOG2R + 2;
  localparam int S  = DW - 1 - ORDER*LOG2R;
  localparam int SL = (S > 0) ? S : 0;
  localparam int SR = (S < 0) ? -S : 0;
  localparam int YW = W + SL;

  logic signed [W-1:0]  integ [ORDER];
  logic signed [W-1:0]  dly [ORDER];
  logic signed [W-1:0]  comb_in [ORDER];
  logic signed [W-1:0]  comb_acc;
  logic signed [W-1:0]  x;
  logic signed [W-1:0]  dec;
  logic                 dec_v;
  logic [LOG2R-1:0]     cnt;
  logic signed [YW-1:0] y_ext;
  logic signed [YW-1:0] y_sh;
  logic [YW-DW:0]       y_top;
  logic signed [DW-1:0] y_sat;

  assign x = sd_in ? W'(1) : '1;

  // Integrators and the block counter only move on accepted bits; wrap is intentional.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) integ[k] <= '0;
      cnt   <= '0;
      dec   <= '0;
      dec_v <= 1'b0;
    end else begin
      dec_v <= 1'b0;
      if (en) begin
        integ[0] <= integ[0] + x;
        for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
        cnt <= cnt + 1'b1;
        if (cnt == '1) begin
          dec   <= integ[ORDER-1];
          dec_v <= 1'b1;
        end
      end
    end
  end

  // Comb chain evaluated combinationally from the captured sample; comb_in[k] is C(k).
  always_comb begin
    comb_acc = dec;
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = comb_acc;
      comb_acc   = comb_acc - dly[k];
    end
  end

  assign y_ext = YW'(comb_acc);
  assign y_sh  = (y_ext <<< SL) >>> SR;
  assign y_top = y_sh[YW-1:DW-1];

  // Saturate when the bits above the output sign bit are not a pure sign extension.
  always_comb begin
    if ((&y_top) || !(|y_top))
      y_sat = y_sh[DW-1:0];
    else if (y_sh[YW-1])
      y_sat = {1'b1, {(DW-1){1'b0}}};
    else
      y_sat = {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) dly[k] <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= dec_v;
      if (dec_v) begin
        out <= y_sat;
        for (int k = 0; k < ORDER; k++) dly[k] <= comb_in[k];
      end
    end
  end

endmodule
